// File: rtl/alu_pkg.sv
// Shared constants for the ALU multiply/divide unit: op codes, widths, FSM encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_CNT_W = 5;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic [ALU_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two's-complement conditioning for alu_muldiv: operand magnitudes before iterating,
// result negation after. Only built with ALU_MULDIV_SIGNED_EN defined.
`ifdef ALU_MULDIV_SIGNED_EN
module muldiv_sign_fix #(
    parameter int WIDTH = 16
) (
    input  logic               signed_en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               neg_q,
    output logic               neg_r,
    input  logic               fix_neg_q,
    input  logic               fix_neg_r,
    input  logic [2*WIDTH-1:0] prod_in,
    input  logic [WIDTH-1:0]   quo_in,
    input  logic [WIDTH-1:0]   rem_in,
    output logic [2*WIDTH-1:0] prod_out,
    output logic [WIDTH-1:0]   quo_out,
    output logic [WIDTH-1:0]   rem_out
);

    logic a_neg;
    logic b_neg;

    assign a_neg = signed_en & a[WIDTH-1];
    assign b_neg = signed_en & b[WIDTH-1];

    // The most negative value maps onto itself, which the unsigned core handles correctly.
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // Product and quotient share a sign rule; the remainder follows the dividend.
    assign neg_q = a_neg ^ b_neg;
    assign neg_r = a_neg;

    assign prod_out = fix_neg_q ? (~prod_in + 1'b1) : prod_in;
    assign quo_out  = fix_neg_q ? (~quo_in + 1'b1)  : quo_in;
    assign rem_out  = fix_neg_r ? (~rem_in + 1'b1)  : rem_in;

endmodule
`endif

// File: rtl/alu_muldiv.sv
// Multi-cycle shift-add multiplier / restoring divider, one bit per clock.
// Define ALU_MULDIV_SIGNED_EN to honour op_signed (two's-complement operands).
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = ALU_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] from_bus,
    input  logic             Y_in,
    input  logic             start,
    input  logic             op,
    input  logic             op_signed,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    state_t             state;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   mcand;      // multiplicand for MUL, divisor for DIV
    logic [2*WIDTH-1:0] acc;        // MUL: {partial sum, multiplier}; DIV: low half dividend/quotient
    logic [WIDTH-1:0]   rem;
    logic [CNT_W-1:0]   count;
    logic               op_q;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_final;
    logic [WIDTH-1:0]   quo_final;
    logic [WIDTH-1:0]   rem_final;

    logic last_iter;
    logic launch;
    logic div_zero_launch;

    assign busy         = (state == BUSY);
    assign result_valid = (state == DONE);
    assign last_iter    = (count == CNT_W'(WIDTH - 1));
    assign launch       = (state == IDLE) && start;
    assign div_zero_launch = (op == OP_DIV) && (from_bus == '0);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        acc_next  = acc;
        rem_next  = rem;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        div_shift = {rem, acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand};
        if (op_q == OP_MUL) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            rem_next = div_trial[WIDTH-1:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = div_shift[WIDTH-1:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
        end
    end

`ifdef ALU_MULDIV_SIGNED_EN
    logic pre_neg_q;
    logic pre_neg_r;
    logic neg_q;
    logic neg_r;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_en (op_signed),
        .a         (opa),
        .b         (from_bus),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .neg_q     (pre_neg_q),
        .neg_r     (pre_neg_r),
        .fix_neg_q (neg_q),
        .fix_neg_r (neg_r),
        .prod_in   (acc_next),
        .quo_in    (acc_next[WIDTH-1:0]),
        .rem_in    (rem_next),
        .prod_out  (prod_final),
        .quo_out   (quo_final),
        .rem_out   (rem_final)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (launch) begin
            neg_q <= pre_neg_q;
            neg_r <= pre_neg_r;
        end
    end
`else
    logic unused_op_signed;

    assign unused_op_signed = op_signed;
    assign a_mag      = opa;
    assign b_mag      = from_bus;
    assign prod_final = acc_next;
    assign quo_final  = acc_next[WIDTH-1:0];
    assign rem_final  = rem_next;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            opa         <= '0;
            mcand       <= '0;
            acc         <= '0;
            rem         <= '0;
            count       <= '0;
            op_q        <= OP_MUL;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            // A start in the same cycle still sees the old opa.
            if (Y_in) begin
                opa <= from_bus;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        count       <= '0;
                        rem         <= '0;
                        div_by_zero <= 1'b0;
                        if (div_zero_launch) begin
                            result_lo   <= DIV0_QUOTIENT;
                            result_hi   <= opa;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            mcand <= (op == OP_MUL) ? a_mag : b_mag;
                            acc   <= {{WIDTH{1'b0}}, ((op == OP_MUL) ? b_mag : a_mag)};
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    rem   <= rem_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state <= DONE;
                        if (op_q == OP_MUL) begin
                            {result_hi, result_lo} <= prod_final;
                        end else begin
                            result_hi <= rem_final;
                            result_lo <= quo_final;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed cases plus randomized ops against an
// arithmetic reference model. Honours ALU_MULDIV_SIGNED_EN the same way as the RTL.
module tb_alu_muldiv;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
`ifdef ALU_MULDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] from_bus;
    logic        Y_in;
    logic        start;
    logic        op;
    logic        op_signed;
    logic        busy;
    logic        result_valid;
    logic [15:0] result_hi;
    logic [15:0] result_lo;
    logic        div_by_zero;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_a;
    logic [31:0] prev_res;

    always #5 clk = ~clk;

    alu_muldiv dut (
        .clk          (clk),
        .reset        (reset),
        .from_bus     (from_bus),
        .Y_in         (Y_in),
        .start        (start),
        .op           (op),
        .op_signed    (op_signed),
        .busy         (busy),
        .result_valid (result_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo),
        .div_by_zero  (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [32:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic op_i, input logic sgn);
        logic [31:0] r;
        int          sa, sb, q, m;
        if (op_i == OP_DIV && b == 16'h0) return {1'b1, a, 16'hFFFF};
        if (!(sgn && SIGNED_BUILD)) begin
            if (op_i == OP_MUL) r = 32'(a) * 32'(b);
            else                r = {16'(a % b), 16'(a / b)};
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (op_i == OP_MUL) begin
                r = 32'(sa * sb);
            end else begin
                q = sa / sb;
                m = sa % sb;
                r = {m[15:0], q[15:0]};
            end
        end
        return {1'b0, r};
    endfunction

    task automatic load_a(input logic [15:0] a);
        from_bus = a;
        Y_in     = 1'b1;
        tick();
        Y_in     = 1'b0;
        model_a  = a;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (result_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] b, input logic op_i,
                          input logic sgn, input logic y_start, input logic mid_y);
        logic [32:0] exp;
        int          lat;
        int          exp_lat;
        exp     = ref_op(model_a, b, op_i, sgn);
        exp_lat = (op_i == OP_DIV && b == 16'h0) ? 1 : 17;
        from_bus  = b;
        op        = op_i;
        op_signed = sgn;
        start     = 1'b1;
        Y_in      = y_start;
        tick();
        start = 1'b0;
        Y_in  = 1'b0;
        if (y_start) model_a = b;
        lat = 1;
        while (result_valid !== 1'b1 && lat < 40) begin
            if (lat == 5) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_hold_busy"}, {result_hi, result_lo}, prev_res);
            end
            if (lat == 6 && mid_y) begin
                from_bus = b ^ 16'h7777;
                model_a  = b ^ 16'h7777;
                Y_in     = 1'b1;
            end
            tick();
            Y_in = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, {result_hi, result_lo}, exp[31:0]);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp[32]));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        prev_res = exp[31:0];
        tick();
        check({tag, "_strobe_fall"}, 32'(result_valid), 32'd0);
        check({tag, "_hold"}, {result_hi, result_lo}, exp[31:0]);
    endtask

    initial begin
        int lat;
        int seen;

        reset     = 1'b1;
        from_bus  = '0;
        Y_in      = 1'b0;
        start     = 1'b0;
        op        = OP_MUL;
        op_signed = 1'b0;
        model_a   = '0;
        prev_res  = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", {result_hi, result_lo}, 32'h0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);

        load_a(16'h00FF);
        run_op("mul_ff", 16'h0101, OP_MUL, 1'b0, 1'b0, 1'b0);
        check("mul_ff_spec", {result_hi, result_lo}, 32'h0000_FFFF);

        load_a(16'hFFFF);
        run_op("mul_max", 16'hFFFF, OP_MUL, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("mul_max_spec_hold", {result_hi, result_lo}, 32'hFFFE_0001);

        load_a(16'd1000);
        run_op("div_1000_7", 16'd7, OP_DIV, 1'b0, 1'b0, 1'b0);
        check("div_1000_7_spec", {result_hi, result_lo}, 32'h0006_008E);

        load_a(16'h1234);
        run_op("div_zero", 16'h0000, OP_DIV, 1'b0, 1'b0, 1'b0);
        check("div_zero_spec", {result_hi, result_lo}, 32'h1234_FFFF);
        check("div_zero_flag", 32'(div_by_zero), 32'd1);
        load_a(16'd9);
        run_op("div_9_3", 16'd3, OP_DIV, 1'b0, 1'b0, 1'b0);
        check("div_9_3_spec", {result_hi, result_lo}, 32'h0000_0003);

        // Second start during BUSY must be ignored.
        load_a(16'd3);
        from_bus = 16'd5;
        op       = OP_MUL;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        from_bus = 16'd9;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(lat);
        check("ignore_latency", 32'(lat + 4), 32'd17);
        check("ignore_result", {result_hi, result_lo}, 32'd15);
        tick();

        // Reset in the middle of an operation aborts it.
        from_bus = 16'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(result_valid), 32'd0);
        check("abort_result", {result_hi, result_lo}, 32'h0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (result_valid === 1'b1) seen++;
            tick();
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        model_a  = '0;
        prev_res = '0;
        run_op("after_abort_a0", 16'd5, OP_MUL, 1'b0, 1'b0, 1'b0);
        load_a(16'd2);
        run_op("mul_2_2", 16'd2, OP_MUL, 1'b0, 1'b0, 1'b0);
        check("mul_2_2_spec", {result_hi, result_lo}, 32'd4);

        // Y_in together with start, and Y_in during BUSY.
        load_a(16'd5);
        run_op("ystart", 16'd3, OP_MUL, 1'b0, 1'b1, 1'b0);
        check("ystart_spec", {result_hi, result_lo}, 32'd15);
        run_op("ystart_next", 16'd4, OP_MUL, 1'b0, 1'b0, 1'b1);
        check("ystart_next_spec", {result_hi, result_lo}, 32'd12);
        run_op("after_mid_y", 16'd2, OP_MUL, 1'b0, 1'b0, 1'b0);

        load_a(16'hFFFA);
        run_op("smul", 16'd7, OP_MUL, 1'b1, 1'b0, 1'b0);
        check("smul_spec", {result_hi, result_lo},
              SIGNED_BUILD ? 32'hFFFF_FFD6 : 32'h0006_FFD6);
        load_a(16'hFFF9);
        run_op("sdiv", 16'd2, OP_DIV, 1'b1, 1'b0, 1'b0);
        check("sdiv_spec", {result_hi, result_lo},
              SIGNED_BUILD ? 32'hFFFF_FFFD : 32'h0001_7FFC);
        load_a(16'h8000);
        run_op("sdiv_wrap", 16'hFFFF, OP_DIV, 1'b1, 1'b0, 1'b0);
        check("sdiv_wrap_spec", {result_hi, result_lo},
              SIGNED_BUILD ? 32'h0000_8000 : 32'h8000_0000);
        load_a(16'hFFFE);
        run_op("sdiv_zero", 16'h0000, OP_DIV, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 16'h0;
            if ($urandom_range(0, 3) != 0) load_a(ra);
            run_op("rnd", rb, 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Multi-cycle multiply/divide unit on the ALU side of the datapath.
- Latches operand A from the 16-bit bus and takes operand B from the bus when an operation is launched.
- Iterates one bit per clock and presents a 32-bit result (hi/lo halves) plus a one-cycle valid strobe.
- The strobe is the source of the Z register's 32-bit capture (hi -> REG_OUT_Z1 half, lo -> REG_OUT_Z2 half).

Parameters:
- WIDTH, 16, operand width and bus width; result is 2*WIDTH.
- CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- from_bus  in  WIDTH  shared datapath bus.
- Y_in  in  1  latch from_bus into operand A register.
- start  in  1  launch operation; from_bus is operand B this cycle.
- op  in  1  0 = MUL, 1 = DIV.
- op_signed  in  1  signed mode; honoured only with the macro.
- busy  out  1  high while an operation is in flight.
- result_valid  out  1  one-cycle strobe, result stable.
- result_hi  out  WIDTH  MUL: product[31:16]; DIV: remainder.
- result_lo  out  WIDTH  MUL: product[15:0]; DIV: quotient.
- div_by_zero  out  1  sticky for the last op; set when DIV divisor is 0.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE; busy=0, result_valid=0, result_hi=0, result_lo=0, div_by_zero=0; operand A=0; counter=0.
- Y_in is honoured in any state and does not disturb an in-flight op, because the operands are copied at start.
- FSM IDLE / BUSY / DONE.
- IDLE: start=1 at edge k copies A and B (from_bus), clears div_by_zero, and goes to BUSY with count=0. busy=1 from edge k.
- IDLE, DIV with B=0: goes straight to DONE. Result lo=0xFFFF, hi=A, div_by_zero=1. result_valid is high in the cycle after edge k.
- BUSY, MUL: unsigned shift-add, one multiplier bit per edge (LSB first). The accumulator is 2*WIDTH wide with no overflow possible.
- BUSY, DIV: restoring division, one quotient bit per edge (MSB first). Partial remainder is WIDTH+1 bits.
- BUSY: after WIDTH iterations (edges k+1..k+16), state goes to DONE.
- DONE: result_valid=1 for exactly one cycle; busy=0 in DONE. Next edge returns to IDLE; result_valid falls.
- Latency: start at edge k -> result_valid high during the cycle after edge k+16 (17 edges). Divide-by-zero: 1 edge.
- result_hi/lo hold their value from DONE until the next accepted start. They are not updated during BUSY (a working register is used).
- start while BUSY or DONE is ignored; no queueing.
- start and Y_in together: start uses the old A, then A updates.
- Reset mid-operation aborts: no result_valid, outputs return to reset values.

Optional Feature:
- Macro: ALU_MULDIV_SIGNED_EN.
- Defined: op_signed=1 treats operands as two's complement. Magnitudes are taken before iterating and result signs are fixed in DONE:
  - product sign = sign(A) xor sign(B);
  - quotient sign = sign(A) xor sign(B);
  - remainder sign = sign(A).
  - Latency is unchanged; sign fix is folded into the BUSY->DONE edge.
  - 0x8000 / 0xFFFF yields lo=0x8000, hi=0 (wraps).
  - Divide-by-zero result is the same as unsigned.
- Undefined: op_signed is ignored; all operations are unsigned.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_MUL=0, OP_DIV=1;
  - WIDTH default;
  - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - DIV0_QUOTIENT = all ones.
- Sub-module muldiv_sign_fix (combinational abs / negate pre- and post-conditioning). It is instantiated only under ALU_MULDIV_SIGNED_EN.
- The iteration datapath and FSM stay in alu_muldiv.

Test Plan:
- MUL unsigned: Y_in with 0x00FF, then start MUL with bus 0x0101 -> busy 16 cycles. result_valid on the 17th edge after start, with hi=0x0000, lo=0xFFFF; strobe width exactly 1 cycle.
- MUL max: 0xFFFF * 0xFFFF -> hi=0xFFFE, lo=0x0001; the result holds after valid falls until the next start.
- DIV: A=1000 (0x03E8), B=7 -> lo=0x008E (142), hi=0x0006, div_by_zero=0.
- DIV by zero: A=0x1234, B=0 -> valid one cycle after start, lo=0xFFFF, hi=0x1234, div_by_zero=1. The next DIV 9/3 clears the flag (lo=3, hi=0).
- Abort and ignore:
  - Start MUL 3*5, assert a second start at busy cycle 4 -> ignored, result 15.
  - Start again, assert reset at busy cycle 8 -> busy=0, no valid, outputs 0.
  - Then 2*2 -> lo=4.
- Signed (macro defined): -6*7 -> hi=0xFFFF, lo=0xFFD6; -7/2 -> lo=0xFFFD, hi=0xFFFF. Macro undefined with op_signed=1: 0xFFFA*7 -> hi=0x0006, lo=0xFFD6.
